fetch_stage: RTL and testbench

//  Instruction fetch stage of the RISC-V core. It holds the PC and issues in-order requests
//  to instruction memory, and buffers returned words in a small FIFO. It presents
//  {Instr, InstrPC, PCPlus4} to decode through a valid/ready handshake; Instr feeds the decoder
//  and the sign extender's Imm input directly. It supports branch/jump redirect with discard of
//  in-flight fetches.

---
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage_if
// Desc   : Instruction-memory and decode handshake bundle for fetch_stage.
// Rev    : 1.0  initial release
// ============================================================================
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRvalid;
  logic [31:0] ImemRdata;
  logic        RedirectEn;
  logic [31:0] RedirectPC;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [31:0] PCPlus4;

  modport master (
    output ImemReq, ImemAddr, InstrValid, Instr, InstrPC, PCPlus4,
    input  ImemGnt, ImemRvalid, ImemRdata, RedirectEn, RedirectPC, InstrReady
  );

  modport slave (
    input  ImemReq, ImemAddr, InstrValid, Instr, InstrPC, PCPlus4,
    output ImemGnt, ImemRvalid, ImemRdata, RedirectEn, RedirectPC, InstrReady
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage
// Desc   : RISC-V fetch: PC, in-order imem requests, response FIFO, redirect.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  localparam int unsigned   AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW  = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic          rst_sync;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight_total;
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;
  logic [AW-1:0] fifo_wr;
  logic [AW-1:0] fifo_rd;
  logic [31:0]   tag_mem    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];

  logic redirect;
  logic fifo_empty;
  logic issue;
  logic rsp;
  logic rsp_keep;
  logic pop;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.RedirectPC[1:0];

  assign redirect       = bus.RedirectEn;
  assign fifo_empty     = (fifo_count == '0);
  // Every outstanding request owns a future FIFO slot, so this sum bounds occupancy.
  assign inflight_total = outstanding + fifo_count;

  assign bus.ImemReq  = rst_sync & ~redirect & (inflight_total < DEPTH_CNT);
  assign bus.ImemAddr = pc;
  assign issue        = bus.ImemReq & bus.ImemGnt;

  // Orphan responses (nothing outstanding) are ignored entirely.
  assign rsp      = bus.ImemRvalid & (outstanding != '0);
  assign rsp_keep = rsp & (discard == '0) & ~redirect;

  assign bus.InstrValid = ~fifo_empty & ~redirect;
  assign pop            = bus.InstrValid & bus.InstrReady;
  assign bus.Instr      = fifo_empty ? '0 : fifo_instr[fifo_rd];
  assign bus.InstrPC    = fifo_empty ? '0 : fifo_pc[fifo_rd];
  assign bus.PCPlus4    = fifo_empty ? '0 : fifo_pc[fifo_rd] + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 1'b0;
    end else begin
      rst_sync <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= {bus.RedirectPC[31:2], 2'b00};
    end else if (issue) begin
      pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + (issue ? ONE : '0) - (rsp ? ONE : '0);
      // Anything still in flight after a redirect belongs to the old path.
      if (redirect) begin
        discard <= outstanding - (rsp ? ONE : '0);
      end else if (rsp && (discard != '0)) begin
        discard <= discard - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else if (redirect) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (issue) begin
        tag_wr <= tag_wr + PTR_ONE;
      end
      if (rsp_keep) begin
        tag_rd <= tag_rd + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[tag_wr] <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else begin
      if (rsp_keep) begin
        fifo_wr <= fifo_wr + PTR_ONE;
      end
      if (pop) begin
        fifo_rd <= fifo_rd + PTR_ONE;
      end
      fifo_count <= fifo_count + (rsp_keep ? ONE : '0) - (pop ? ONE : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      fifo_instr[fifo_wr] <= bus.ImemRdata;
      fifo_pc[fifo_wr]    <= tag_mem[tag_rd];
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.ImemRvalid && (outstanding == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_stage
// Desc   : Directed bench for fetch_stage with a queue-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference state: fetches in flight (live = still on the current path),
  // and the PCs of words waiting for decode.
  typedef struct packed {
    logic [31:0] addr;
    logic        live;
  } flight_t;

  flight_t     infl[$];
  logic [31:0] fifo_q[$];
  logic [31:0] m_pc;
  bit          alive;
  bit          gnt_s, ready_s, rsp_s;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick(input bit redir, input logic [31:0] rpc);
    bit          exp_req, exp_valid, rsp, issue, pop;
    logic [31:0] head;
    flight_t     f;
    bus.ImemGnt    = gnt_s;
    bus.InstrReady = ready_s;
    bus.RedirectEn = redir;
    bus.RedirectPC = rpc;
    rsp            = rsp_s && (infl.size() > 0);
    bus.ImemRvalid = rsp;
    bus.ImemRdata  = rsp ? word_at(infl[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_req   = alive && !redir && ((infl.size() + fifo_q.size()) < DEPTH);
    exp_valid = (fifo_q.size() > 0) && !redir;
    head      = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    chk("ImemReq",    32'(bus.ImemReq),    32'(exp_req));
    chk("ImemAddr",   bus.ImemAddr,        m_pc);
    chk("InstrValid", 32'(bus.InstrValid), 32'(exp_valid));
    if (fifo_q.size() > 0) begin
      chk("Instr",   bus.Instr,   word_at(head));
      chk("InstrPC", bus.InstrPC, head);
      chk("PCPlus4", bus.PCPlus4, head + 32'd4);
    end else begin
      chk("Instr_empty",   bus.Instr,   32'h0);
      chk("InstrPC_empty", bus.InstrPC, 32'h0);
      chk("PCPlus4_empty", bus.PCPlus4, 32'h0);
    end
    issue = exp_req && gnt_s;
    pop   = exp_valid && ready_s;
    if (pop) void'(fifo_q.pop_front());
    if (rsp) begin
      f = infl.pop_front();
      if (f.live && !redir) fifo_q.push_back(f.addr);
    end
    if (redir) begin
      fifo_q.delete();
      foreach (infl[i]) infl[i].live = 1'b0;
      m_pc = {rpc[31:2], 2'b00};
    end else if (issue) begin
      infl.push_back('{addr: m_pc, live: 1'b1});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    alive = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    gnt_s   = 1'b0;
    rsp_s   = 1'b1;
    ready_s = 1'b1;
    repeat (5) tick(1'b0, 32'h0);
  endtask

  initial begin
    bus.ImemGnt    = 1'b0;
    bus.ImemRvalid = 1'b0;
    bus.ImemRdata  = 32'h0;
    bus.RedirectEn = 1'b0;
    bus.RedirectPC = 32'h0;
    bus.InstrReady = 1'b0;
    m_pc    = 32'h0;
    alive   = 1'b0;
    gnt_s   = 1'b1;
    ready_s = 1'b1;
    rsp_s   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Streaming from reset: first word at PC 0, then PC 4.
    repeat (3) tick(1'b0, 32'h0);
    chk("t1_first_valid", 32'(bus.InstrValid), 32'h1);
    chk("t1_first_pc",    bus.InstrPC,         32'h0);
    chk("t1_first_pc4",   bus.PCPlus4,         32'h4);
    tick(1'b0, 32'h0);
    chk("t1_second_pc",   bus.InstrPC,         32'h4);
    repeat (8) tick(1'b0, 32'h0);

    // Decode stalls: FIFO fills, requests stop, then ordered drain.
    ready_s = 1'b0;
    repeat (10) tick(1'b0, 32'h0);
    chk("t2_req_stopped", 32'(bus.ImemReq),    32'h0);
    chk("t2_fifo_full",   32'(bus.InstrValid), 32'h1);
    ready_s = 1'b1;
    repeat (8) tick(1'b0, 32'h0);

    // Redirect with two fetches in flight.
    drain();
    gnt_s = 1'b1;
    rsp_s = 1'b0;
    tick(1'b1, 32'h10);
    repeat (2) tick(1'b0, 32'h0);
    chk("t3_two_inflight_req", 32'(bus.ImemReq), 32'h0);
    chk("t3_pc_after_two",     bus.ImemAddr,     32'h18);
    tick(1'b1, 32'h103);
    rsp_s = 1'b1;
    repeat (3) tick(1'b0, 32'h0);
    chk("t3_target_valid", 32'(bus.InstrValid), 32'h1);
    chk("t3_target_pc",    bus.InstrPC,         32'h100);
    chk("t3_target_instr", bus.Instr,           32'hFFFF_FEFF);

    // Redirect coinciding with a response and a grant.
    drain();
    gnt_s = 1'b1;
    rsp_s = 1'b0;
    tick(1'b1, 32'h200);
    repeat (2) tick(1'b0, 32'h0);
    rsp_s = 1'b1;
    tick(1'b1, 32'h300);
    repeat (2) tick(1'b0, 32'h0);
    chk("t4_target_pc",    bus.InstrPC, 32'h300);
    chk("t4_target_instr", bus.Instr,   32'hFFFF_FCFF);
    repeat (3) tick(1'b0, 32'h0);

    // Grant withheld: address held, then exactly one issue.
    drain();
    tick(1'b1, 32'h400);
    repeat (5) tick(1'b0, 32'h0);
    chk("t5_addr_held", bus.ImemAddr,     32'h400);
    chk("t5_req_held",  32'(bus.ImemReq), 32'h1);
    gnt_s = 1'b1;
    tick(1'b0, 32'h0);
    gnt_s = 1'b0;
    chk("t5_single_issue", bus.ImemAddr, 32'h404);
    repeat (3) tick(1'b0, 32'h0);

    // PC wrap at the top of the address space.
    drain();
    gnt_s   = 1'b1;
    ready_s = 1'b0;
    tick(1'b1, 32'hFFFF_FFFF);
    tick(1'b0, 32'h0);
    chk("t6_addr_wrap", bus.ImemAddr, 32'h0);
    tick(1'b0, 32'h0);
    chk("t6_top_pc",    bus.InstrPC, 32'hFFFF_FFFC);
    chk("t6_pc4_wrap",  bus.PCPlus4, 32'h0);

    // Asynchronous reset in the middle of traffic.
    #3;
    rst_n          = 1'b0;
    bus.ImemRvalid = 1'b0;
    #1;
    chk("t6_rst_req",   32'(bus.ImemReq),    32'h0);
    chk("t6_rst_valid", 32'(bus.InstrValid), 32'h0);
    chk("t6_rst_instr", bus.Instr,           32'h0);
    chk("t6_rst_pc",    bus.InstrPC,         32'h0);
    chk("t6_rst_pc4",   bus.PCPlus4,         32'h0);
    chk("t6_rst_addr",  bus.ImemAddr,        32'h0);
    infl.delete();
    fifo_q.delete();
    m_pc  = 32'h0;
    alive = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    ready_s = 1'b1;
    rsp_s   = 1'b1;
    repeat (6) tick(1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
